// File: rtl/addsub_arbiter.sv
// addsub_arbiter: several requesters share one adder/subtractor through a
// round-robin arbiter. Results go into a single registered response slot
// with a valid/ready handshake.
//
// Ports:
//   clk          - clock; all state changes on the rising edge
//   rst_n        - asynchronous active-low reset
//   req_valid    - per-requester "operation present"
//   req_ready    - per-requester accept strobe (one-hot or zero, combinational)
//   req_a/req_b  - packed operands, slice i*WIDTH +: WIDTH belongs to requester i
//   req_sub      - per-requester op select: 1 = A-B, 0 = A+B
//   rsp_valid    - response slot holds a result
//   rsp_ready    - consumer takes the response this cycle
//   rsp_id       - requester index that owns the response
//   rsp_result   - registered sum/difference, modulo 2^WIDTH
//   rsp_cout     - registered carry-out (for subtract, 1 = no borrow)
//   rsp_overflow - registered two's-complement overflow
//   rsp_zero     - registered result == 0

// adder_subtractor: combinational A+B or A-B with carry, overflow and zero.
//   a, b     - operands
//   sub      - 1 = A-B, 0 = A+B
//   result   - sum/difference modulo 2^WIDTH
//   cout     - carry-out (subtract: 1 = no borrow)
//   overflow - two's-complement overflow
//   zero     - result == 0
module adder_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    always_comb begin
        // Subtraction is A + ~B + 1.
        b_eff    = sub ? ~b : b;
        sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        result   = sum[WIDTH-1:0];
        cout     = sum[WIDTH];
        overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
        zero     = (result == '0);
    end
endmodule

module addsub_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_sub,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_cout,
    output logic                  rsp_overflow,
    output logic                  rsp_zero
);
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   grant_id;
    logic             found;
    logic             slot_free;
    logic             grant;
    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_sub;
    logic [WIDTH-1:0] alu_result;
    logic             alu_cout;
    logic             alu_overflow;
    logic             alu_zero;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
        assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
    end

    // Round-robin search starting at ptr, wrapping modulo NREQ.
    always_comb begin
        int unsigned idx;
        found    = 1'b0;
        grant_id = '0;
        idx      = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                grant_id = IDW'(idx);
            end
        end
    end

    // Gated with rst_n so no accept strobe leaks out while reset is held.
    assign slot_free = !rsp_valid || rsp_ready;
    assign grant     = rst_n && slot_free && found;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign sel_a   = a_arr[grant_id];
    assign sel_b   = b_arr[grant_id];
    assign sel_sub = req_sub[grant_id];

    adder_subtractor #(.WIDTH(WIDTH)) u_alu (
        .a        (sel_a),
        .b        (sel_b),
        .sub      (sel_sub),
        .result   (alu_result),
        .cout     (alu_cout),
        .overflow (alu_overflow),
        .zero     (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_result   <= '0;
            rsp_cout     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            ptr          <= '0;
        end else if (grant) begin
            rsp_valid    <= 1'b1;
            rsp_id       <= grant_id;
            rsp_result   <= alu_result;
            rsp_cout     <= alu_cout;
            rsp_overflow <= alu_overflow;
            rsp_zero     <= alu_zero;
            ptr          <= (32'(grant_id) == NREQ - 1) ? '0 : grant_id + IDW'(1);
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter (WIDTH=8, NREQ=4): table vectors,
// directed arbitration/reset sequences and randomized traffic against a
// behavioural model.
module tb_addsub_arbiter;
    localparam int W   = 8;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_sub;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [W-1:0]     rsp_result;
    logic             rsp_cout;
    logic             rsp_overflow;
    logic             rsp_zero;

    addsub_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_sub      (req_sub),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_cout     (rsp_cout),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int m_ptr;
    bit m_valid;
    int m_id;
    int m_result;
    bit m_cout;
    bit m_ovf;
    bit m_zero;
    int last_grant;
    int wait_cnt [N];

    typedef struct {
        int   id;
        int   a;
        int   b;
        bit   sub;
        int   result;
        bit   cout;
        bit   ovf;
        bit   zero;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain-integer arithmetic reference: {cout, ovf, zero, result[7:0]}
    function automatic logic [10:0] ref_op(input int a, input int b, input bit sub);
        int r, sa, sb, sr;
        bit c, o, z;
        r  = sub ? a - b : a + b;
        c  = sub ? (a >= b) : (r >= 256);
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        sr = sub ? sa - sb : sa + sb;
        o  = (sr > 127) || (sr < -128);
        z  = ((r & 255) == 0);
        return {c, o, z, 8'(r & 255)};
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 0;
        m_id    = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    endtask

    // Called at posedge+1 with inputs already driven; returns at next posedge+1.
    task automatic cycle();
        int g;
        logic [N-1:0] exp_rdy;
        logic [10:0]  r;
        #4;
        g = -1;
        if (!m_valid || rsp_ready) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        exp_rdy = (g >= 0) ? N'(1 << g) : '0;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        last_grant = g;
        if (g >= 0) begin
            check("fairness", wait_cnt[g], (wait_cnt[g] < N) ? wait_cnt[g] : N - 1);
            for (int i = 0; i < N; i++) begin
                if (i == g) wait_cnt[i] = 0;
                else if (req_valid[i]) wait_cnt[i]++;
            end
            r        = ref_op(int'(req_a[g*W +: W]), int'(req_b[g*W +: W]), req_sub[g]);
            m_valid  = 1;
            m_id     = g;
            m_result = int'(r[7:0]);
            m_zero   = r[8];
            m_ovf    = r[9];
            m_cout   = r[10];
            m_ptr    = (g + 1) % N;
        end else if (m_valid && rsp_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        if (m_valid) begin
            check("rsp_id", 32'(rsp_id), m_id);
            check("rsp_result", 32'(rsp_result), m_result);
            check("rsp_cout", 32'(rsp_cout), 32'(m_cout));
            check("rsp_overflow", 32'(rsp_overflow), 32'(m_ovf));
            check("rsp_zero", 32'(rsp_zero), 32'(m_zero));
        end
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        check("rst_valid", 32'(rsp_valid), 0);
        check("rst_id", 32'(rsp_id), 0);
        check("rst_result", 32'(rsp_result), 0);
        check("rst_flags", {29'd0, rsp_cout, rsp_overflow, rsp_zero}, 0);
        check("rst_req_ready", 32'(req_ready), 0);
        req_valid = '0;
        rst_n     = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [W-1:0] snap;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        rsp_ready = 1'b0;

        vecs[0] = '{2, 'h7F, 'h01, 0, 'h80, 0, 1, 0};
        vecs[1] = '{1, 'h05, 'h05, 1, 'h00, 1, 0, 1};
        vecs[2] = '{1, 'h00, 'h01, 1, 'hFF, 0, 0, 0};
        vecs[3] = '{0, 'hFF, 'h01, 0, 'h00, 1, 0, 1};
        vecs[4] = '{3, 'h80, 'h01, 1, 'h7F, 1, 1, 0};
        vecs[5] = '{0, 'h80, 'h80, 0, 'h00, 1, 1, 1};
        vecs[6] = '{3, 'h7F, 'hFF, 1, 'h80, 0, 1, 0};
        vecs[7] = '{2, 'h12, 'h34, 0, 'h46, 0, 0, 0};

        apply_reset();

        // Single active requester: granted every cycle whatever ptr is.
        rsp_ready = 1'b1;
        foreach (vecs[v]) begin
            req_valid                  = N'(1 << vecs[v].id);
            req_a[vecs[v].id*W +: W]   = W'(vecs[v].a);
            req_b[vecs[v].id*W +: W]   = W'(vecs[v].b);
            req_sub[vecs[v].id]        = vecs[v].sub;
            cycle();
            check("vec_grant", last_grant, vecs[v].id);
            check("vec_id", 32'(rsp_id), vecs[v].id);
            check("vec_result", 32'(rsp_result), vecs[v].result);
            check("vec_cout", 32'(rsp_cout), 32'(vecs[v].cout));
            check("vec_ovf", 32'(rsp_overflow), 32'(vecs[v].ovf));
            check("vec_zero", 32'(rsp_zero), 32'(vecs[v].zero));
        end
        req_valid = '0;
        cycle();

        // All requesters held valid: 0,1,2,3,0,1 back to back.
        apply_reset();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = W'(8'h10 * i + 3);
            req_b[i*W +: W] = W'(8'h21 + i);
        end
        req_sub   = 4'b0101;
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("rr_order", last_grant, k % N);
            check("rr_rsp_id", 32'(rsp_id), k % N);
        end

        // Stall with response pending: nothing accepted, outputs frozen.
        rsp_ready = 1'b0;
        req_valid = 4'b1001;
        snap      = rsp_result;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("stall_grant", last_grant, -1);
            check("stall_result", 32'(rsp_result), 32'(snap));
            check("stall_id", 32'(rsp_id), 1);
        end
        rsp_ready = 1'b1;
        cycle();
        check("resume_grant", last_grant, 3);

        // Drain with no new request.
        req_valid = '0;
        cycle();
        check("drain_valid", 32'(rsp_valid), 0);

        // Asynchronous reset with ptr=3 and a held response.
        req_valid = 4'b0100;
        cycle();
        check("pre_rst_valid", 32'(rsp_valid), 1);
        req_valid = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("async_rst_valid", 32'(rsp_valid), 0);
        check("async_rst_result", 32'(rsp_result), 0);
        apply_reset();
        req_valid = 4'b1010;
        rsp_ready = 1'b1;
        cycle();
        check("post_rst_grant", last_grant, 1);
        req_valid = '0;
        rsp_ready = 1'b1;
        cycle();

        // Randomized traffic; a requester holds its operation until granted.
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_grant == i) begin
                    req_valid[i]    = ($urandom_range(0, 2) != 0);
                    req_a[i*W +: W] = W'($urandom);
                    req_b[i*W +: W] = W'($urandom);
                    req_sub[i]      = 1'($urandom);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
